// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings, approach indices and light codes shared by light controllers
package traffic_pkg;
   localparam logic [1:0] PH_GREEN  = 2'd0;
   localparam logic [1:0] PH_YELLOW = 2'd1;
   localparam logic [1:0] PH_ALLRED = 2'd2;
   localparam int N = 0;
   localparam int E = 1;
   localparam int S = 2;
   localparam int W = 3;
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle tick every CNT_MAX clocks; ports CLOCK_50, KEY (async active-low reset), tick
module tick_gen #(
   parameter int CNT_MAX = 50000000
) (
   input  logic CLOCK_50,
   input  logic KEY,
   output logic tick
);
   localparam int CW = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick = cnt_q == CW'(CNT_MAX - 1);
   always_comb cnt_d = tick ? '0 : cnt_q + CW'(1);
   always_ff @(posedge CLOCK_50 or negedge KEY)
      if (!KEY) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: round-robin 4-way signal scheduler; in CLOCK_50, KEY, REQ[3:0]; out LED_ALL[11:0], GRANT[3:0], PHASE[1:0], SEC[5:0]
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int CNT_MAX   = 50000000,
   parameter int T_MIN_GRN = 10,
   parameter int T_MAX_GRN = 30,
   parameter int T_YEL     = 5,
   parameter int T_ALLRED  = 2
) (
   input  logic        CLOCK_50,
   input  logic        KEY,
   input  logic [3:0]  REQ,
   output logic [11:0] LED_ALL,
   output logic [3:0]  GRANT,
   output logic [1:0]  PHASE,
   output logic [5:0]  SEC
);
   logic       tick;
   logic [1:0] phase_q, phase_d;
   logic [3:0] grant_q, grant_d, pend_q, pend_d, others, clr;
   logic [5:0] sec_q, sec_d, sec_n;
   logic       go_yel, go_ar, go_grn;

   tick_gen #(.CNT_MAX(CNT_MAX)) u_tick (.CLOCK_50(CLOCK_50), .KEY(KEY), .tick(tick));

   // first pending approach after the owner, walking owner+1..owner+3; keeps the owner if none
   function automatic logic [3:0] rr_pick(input logic [3:0] g, input logic [3:0] p);
      logic [3:0] c, r;
      logic       f;
      c = g;
      r = g;
      f = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c = {c[2:0], c[3]};
         if (!f && (c & p) != 4'b0) begin
            r = c;
            f = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      sec_n   = (sec_q == 6'd63) ? sec_q : sec_q + 6'd1;
      others  = pend_q & ~grant_q;
      go_yel  = tick && phase_q == PH_GREEN && sec_n >= 6'(T_MIN_GRN) && others != 4'b0 &&
                ((REQ & grant_q) == 4'b0 || sec_n >= 6'(T_MAX_GRN));
      go_ar   = tick && phase_q == PH_YELLOW && sec_n == 6'(T_YEL);
      go_grn  = tick && phase_q == PH_ALLRED && sec_n == 6'(T_ALLRED);
      clr     = go_grn ? rr_pick(grant_q, pend_q) : 4'b0;
      // owner's own request is masked; the newly granted bit is cleared even if requested this cycle
      pend_d  = (pend_q | (REQ & ~grant_q)) & ~clr;
      grant_d = go_grn ? clr : grant_q;
      phase_d = go_yel ? PH_YELLOW : go_ar ? PH_ALLRED : go_grn ? PH_GREEN : phase_q;
      sec_d   = !tick ? sec_q : (go_yel || go_ar || go_grn) ? 6'd0 : sec_n;
   end

   always_ff @(posedge CLOCK_50 or negedge KEY)
      if (!KEY) begin
         phase_q <= PH_GREEN;
         grant_q <= 4'(1) << N;
         sec_q   <= 6'd0;
         pend_q  <= 4'b0;
      end else begin
         phase_q <= phase_d;
         grant_q <= grant_d;
         sec_q   <= sec_d;
         pend_q  <= pend_d;
      end

   always_comb begin
      LED_ALL = {4{LT_RED}};
      for (int i = 0; i < 4; i++)
         LED_ALL[3*i +: 3] = !grant_q[i] ? LT_RED :
                             phase_q == PH_GREEN  ? LT_GRN :
                             phase_q == PH_YELLOW ? LT_YEL : LT_RED;
   end

   assign GRANT = grant_q;
   assign PHASE = phase_q;
   assign SEC   = sec_q;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed table-driven bench for intersection_scheduler with short timers
module tb_intersection_scheduler;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
   logic        clk = 1'b0;
   logic        key = 1'b0;
   logic [3:0]  req = 4'b0;
   logic [11:0] led;
   logic [3:0]  grant;
   logic [1:0]  phase;
   logic [5:0]  sec;
   int tests = 0, fails = 0;

   typedef struct {
      string       name;
      bit          rst;
      int          n;
      logic [3:0]  req;
      logic [3:0]  g;
      logic [1:0]  ph;
      logic [5:0]  s;
      logic [11:0] led;
   } vec_t;
   vec_t v[$];

   intersection_scheduler #(
      .CNT_MAX(4), .T_MIN_GRN(3), .T_MAX_GRN(6), .T_YEL(2), .T_ALLRED(1)
   ) dut (
      .CLOCK_50(clk), .KEY(key), .REQ(req),
      .LED_ALL(led), .GRANT(grant), .PHASE(phase), .SEC(sec)
   );

   always #5 clk = ~clk;

   task automatic add(input string nm, input bit rst, input int n, input logic [3:0] rq,
                      input logic [3:0] g, input logic [1:0] ph, input logic [5:0] s, input logic [11:0] l);
      vec_t t;
      t.name = nm; t.rst = rst; t.n = n; t.req = rq; t.g = g; t.ph = ph; t.s = s; t.led = l;
      v.push_back(t);
   endtask

   task automatic check(input string nm, input logic [3:0] g, input logic [1:0] ph,
                        input logic [5:0] s, input logic [11:0] l);
      tests++;
      if (grant !== g || phase !== ph || sec !== s || led !== l) begin
         fails++;
         $display("FAIL %s: got grant=%b phase=%0d sec=%0d led=%b, expected grant=%b phase=%0d sec=%0d led=%b",
                  nm, grant, phase, sec, led, g, ph, s, l);
      end
   endtask

   task automatic do_reset();
      key = 1'b0;
      req = 4'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      key = 1'b1;
   endtask

   initial begin
      // idle: N rests green, SEC counts one per 4 cycles and saturates at 63
      add("idle_e3",   1, 3,   4'b0000, 4'b0001, 2'd0, 6'd0,  {R,R,R,G});
      add("idle_e4",   0, 1,   4'b0000, 4'b0001, 2'd0, 6'd1,  {R,R,R,G});
      add("idle_e200", 0, 196, 4'b0000, 4'b0001, 2'd0, 6'd50, {R,R,R,G});
      add("idle_e252", 0, 52,  4'b0000, 4'b0001, 2'd0, 6'd63, {R,R,R,G});
      add("idle_e260", 0, 8,   4'b0000, 4'b0001, 2'd0, 6'd63, {R,R,R,G});
      // one-cycle E pulse: yellow at tick 3, all-red 2 ticks later, E green 1 tick after
      add("pulse_e1",  1, 1,   4'b0000, 4'b0001, 2'd0, 6'd0,  {R,R,R,G});
      add("pulse_e2",  0, 1,   4'b0010, 4'b0001, 2'd0, 6'd0,  {R,R,R,G});
      add("pulse_e11", 0, 9,   4'b0000, 4'b0001, 2'd0, 6'd2,  {R,R,R,G});
      add("pulse_e12", 0, 1,   4'b0000, 4'b0001, 2'd1, 6'd0,  {R,R,R,Y});
      add("pulse_e16", 0, 4,   4'b0000, 4'b0001, 2'd1, 6'd1,  {R,R,R,Y});
      add("pulse_e20", 0, 4,   4'b0000, 4'b0001, 2'd2, 6'd0,  {R,R,R,R});
      add("pulse_e23", 0, 3,   4'b0000, 4'b0001, 2'd2, 6'd0,  {R,R,R,R});
      add("pulse_e24", 0, 1,   4'b0000, 4'b0010, 2'd0, 6'd0,  {R,R,G,R});
      add("pulse_e64", 0, 40,  4'b0000, 4'b0010, 2'd0, 6'd10, {R,R,G,R});
      // N and S held: N keeps green until max, then S; S likewise until max
      add("max_e12",   1, 12,  4'b0101, 4'b0001, 2'd0, 6'd3,  {R,R,R,G});
      add("max_e23",   0, 11,  4'b0101, 4'b0001, 2'd0, 6'd5,  {R,R,R,G});
      add("max_e24",   0, 1,   4'b0101, 4'b0001, 2'd1, 6'd0,  {R,R,R,Y});
      add("max_e36",   0, 12,  4'b0101, 4'b0100, 2'd0, 6'd0,  {R,G,R,R});
      add("max_e59",   0, 23,  4'b0101, 4'b0100, 2'd0, 6'd5,  {R,G,R,R});
      add("max_e60",   0, 1,   4'b0101, 4'b0100, 2'd1, 6'd0,  {R,Y,R,R});
      // pending 1110 from N: E, S, W in turn, then W rests
      add("rr_e1",     1, 1,   4'b1110, 4'b0001, 2'd0, 6'd0,  {R,R,R,G});
      add("rr_e24",    0, 23,  4'b0000, 4'b0010, 2'd0, 6'd0,  {R,R,G,R});
      add("rr_e48",    0, 24,  4'b0000, 4'b0100, 2'd0, 6'd0,  {R,G,R,R});
      add("rr_e72",    0, 24,  4'b0000, 4'b1000, 2'd0, 6'd0,  {G,R,R,R});
      add("rr_e152",   0, 80,  4'b0000, 4'b1000, 2'd0, 6'd20, {G,R,R,R});
      // S requested again in its own grant cycle: cleared, no second S turn after E
      add("clr_e1",    1, 1,   4'b0100, 4'b0001, 2'd0, 6'd0,  {R,R,R,G});
      add("clr_e23",   0, 22,  4'b0000, 4'b0001, 2'd2, 6'd0,  {R,R,R,R});
      add("clr_e24",   0, 1,   4'b0100, 4'b0100, 2'd0, 6'd0,  {R,G,R,R});
      add("clr_e25",   0, 1,   4'b0010, 4'b0100, 2'd0, 6'd0,  {R,G,R,R});
      add("clr_e48",   0, 23,  4'b0000, 4'b0010, 2'd0, 6'd0,  {R,R,G,R});
      add("clr_e88",   0, 40,  4'b0000, 4'b0010, 2'd0, 6'd10, {R,R,G,R});

      foreach (v[i]) begin
         if (v[i].rst) do_reset();
         req = v[i].req;
         repeat (v[i].n) @(posedge clk);
         #1;
         check(v[i].name, v[i].g, v[i].ph, v[i].s, v[i].led);
      end

      // asynchronous reset during E yellow, then first tick 4 cycles after release
      do_reset();
      req = 4'b1110;
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (37) @(posedge clk);
      #1;
      check("arst_pre", 4'b0010, 2'd1, 6'd0, {R,R,Y,R});
      key = 1'b0;
      #1;
      check("arst_now", 4'b0001, 2'd0, 6'd0, {R,R,R,G});
      @(posedge clk); #1;
      check("arst_next", 4'b0001, 2'd0, 6'd0, {R,R,R,G});
      @(negedge clk);
      key = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("arst_c3", 4'b0001, 2'd0, 6'd0, {R,R,R,G});
      @(posedge clk); #1;
      check("arst_c4", 4'b0001, 2'd0, 6'd1, {R,R,R,G});
      repeat (76) @(posedge clk);
      #1;
      check("arst_c80", 4'b0001, 2'd0, 6'd20, {R,R,R,G});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
